// File: rtl/imem_loader_if.sv
// Byte-stream source and instruction-memory write port of the loader.
// master = host/memory side, slave = loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory programmer: length-prefixed little-endian byte
// stream to consecutive word writes, checked by a trailing XOR byte.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, CSUM
  } state_t;

  state_t           state;
  logic [7:0]       len_lo;
  logic [CNT_W-1:0] len;
  logic [1:0]       idx;
  logic [7:0]       csum;
  logic [23:0]      word;
  logic             fire;
  logic             last;
  logic [15:0]      n;

  assign fire = bus.in_valid & bus.in_ready;
  assign n    = {bus.in_data, len_lo};
  assign last = (words_written + CNT_W'(1)) == len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_lo        <= '0;
      len           <= '0;
      idx           <= '0;
      csum          <= '0;
      word          <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= LEN0;
            bus.in_ready  <= 1'b1;
            cpu_hold      <= 1'b1;
            error         <= 1'b0;
            words_written <= '0;
            idx           <= '0;
            csum          <= '0;
          end
        end
        LEN0: begin
          if (fire) begin
            len_lo <= bus.in_data;
            state  <= LEN1;
          end
        end
        LEN1: begin
          if (fire) begin
            if (n == 16'd0 || n > 16'(DEPTH)) begin
              error        <= 1'b1;
              state        <= IDLE;
              bus.in_ready <= 1'b0;
              cpu_hold     <= 1'b0;
            end else begin
              len   <= n[CNT_W-1:0];
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (fire) begin
            csum <= csum ^ bus.in_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {{(30-CNT_W){1'b0}}, words_written, 2'b00};
              bus.mem_wdata <= {bus.in_data, word};
              words_written <= words_written + CNT_W'(1);
              if (last) state <= CSUM;
            end else begin
              word[{idx, 3'b000} +: 8] <= bus.in_data;
            end
          end
        end
        CSUM: begin
          if (fire) begin
            if (bus.in_data == csum) done <= 1'b1;
            else error <= 1'b1;
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            cpu_hold     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected
// memory writes plus directed checks on handshake and status.
module tb_imem_loader;
  localparam int DEPTH = 1024;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cpu_hold;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_written;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (done === 1'b1) done_cnt++;
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", {32'd0, bus.mem_addr}, 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {32'd0, bus.mem_addr}, {32'd0, e[63:32]});
        chk("wr_data", {32'd0, bus.mem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives the first nbytes of s; the model pushes each expected write
  // when the 4th byte of a word is driven.
  task automatic send(input logic [7:0] s[$], input int gap,
                      input int mid_start, input int nbytes);
    int          n;
    logic [31:0] w;
    n = {s[1], s[0]};
    w = '0;
    for (int i = 0; i < nbytes; i++) begin
      bit wr;
      wr = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (i == mid_start && g == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      if (i >= 2 && n >= 1 && n <= DEPTH && i < 2 + 4 * n) begin
        int p;
        p = i - 2;
        w[8 * (p % 4) +: 8] = s[i];
        if (p % 4 == 3) begin
          sb.push_back({32'(4 * (p / 4)), w});
          wr = 1'b1;
        end
      end
      tick();
      bus.in_valid = 1'b0;
      if (wr) chk("we_next_cycle", {63'd0, bus.mem_we}, 64'd1);
    end
  endtask

  task automatic good_load(input logic [7:0] s[$], input int gap,
                           input int mid_start);
    int d0;
    pulse_start();
    chk("start_hold", {63'd0, cpu_hold}, 64'd1);
    chk("start_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("start_clr_err", {63'd0, error}, 64'd0);
    d0 = done_cnt;
    send(s, gap, mid_start, s.size());
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("ok_error", {63'd0, error}, 64'd0);
    chk("ok_words", {53'd0, words_written}, 64'd2);
    chk("end_hold", {63'd0, cpu_hold}, 64'd0);
    chk("end_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] len0[$];
    logic [7:0] lenbig[$];
    int         d0;

    good   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
               8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
    bad    = good;
    bad[10] = 8'h00;
    len0   = '{8'h00, 8'h00, 8'h55, 8'hAA, 8'h12};
    lenbig = '{8'h01, 8'h04, 8'h55, 8'hAA, 8'h12};

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) tick();
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_addr", {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("rst_hold", {63'd0, cpu_hold}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_words", {53'd0, words_written}, 64'd0);
    rst = 1'b0;
    tick();

    // two-word load, back to back
    good_load(good, 0, -1);
    repeat (2) tick();

    // checksum mismatch
    pulse_start();
    d0 = done_cnt;
    send(bad, 0, -1, bad.size());
    chk("bad_error", {63'd0, error}, 64'd1);
    chk("bad_hold", {63'd0, cpu_hold}, 64'd0);
    chk("bad_words", {53'd0, words_written}, 64'd2);
    repeat (5) tick();
    chk("bad_sticky", {63'd0, error}, 64'd1);
    chk("bad_no_done", 64'(done_cnt - d0), 64'd0);
    chk("bad_sb_empty", 64'(sb.size()), 64'd0);

    // length 0, then keep driving: nothing may be consumed or written
    pulse_start();
    chk("len0_clr_err", {63'd0, error}, 64'd0);
    send(len0, 0, -1, 2);
    chk("len0_error", {63'd0, error}, 64'd1);
    chk("len0_hold", {63'd0, cpu_hold}, 64'd0);
    chk("len0_ready", {63'd0, bus.in_ready}, 64'd0);
    send(len0, 0, -1, len0.size());
    chk("len0_words", {53'd0, words_written}, 64'd0);
    chk("len0_ready2", {63'd0, bus.in_ready}, 64'd0);

    // length over DEPTH
    pulse_start();
    send(lenbig, 0, -1, 2);
    chk("big_error", {63'd0, error}, 64'd1);
    chk("big_hold", {63'd0, cpu_hold}, 64'd0);
    send(lenbig, 0, -1, lenbig.size());
    chk("big_words", {53'd0, words_written}, 64'd0);
    chk("big_sb_empty", 64'(sb.size()), 64'd0);

    // gaps of 3 idle cycles, with a stray start during the payload
    good_load(good, 3, 6);

    // reset after 6 payload bytes
    pulse_start();
    send(good, 0, -1, 8);
    chk("pre_rst_words", {53'd0, words_written}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_hold", {63'd0, cpu_hold}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("mid_rst_addr", {32'd0, bus.mem_addr}, 64'd0);
    chk("mid_rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("mid_rst_words", {53'd0, words_written}, 64'd0);
    chk("mid_rst_error", {63'd0, error}, 64'd0);
    chk("mid_rst_sb", 64'(sb.size()), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // fresh load after reset
    good_load(good, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer that writes a program image into the instruction memory before the core runs. It sits between a host-side byte source and the instruction memory write port. It holds the core in reset while loading, assembles little-endian 32-bit words, and writes them to consecutive word addresses from 0. A trailing XOR checksum validates the image.

## Interface
Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; maximum accepted word count.
- CNT_W, 11, width of `words_written`; must hold DEPTH.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE.
- in_valid  input  1  source has a byte on `in_data`.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle. A byte transfers when `in_valid & in_ready`.
- mem_we  output  1  one-cycle instruction-memory write strobe.
- mem_addr  output  32  byte address of the write; always word aligned (bits [1:0] = 0).
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  holds the core in reset while a load is in progress.
- done  output  1  one-cycle pulse: load finished and checksum matched.
- error  output  1  sticky; set on a bad length or checksum mismatch; cleared by the next accepted `start`.
- words_written  output  CNT_W  number of words written in the current or last load.

## Operation
- Stream format:
  - LEN_LO, LEN_HI: word count N, 16-bit little-endian.
  - Then N×4 payload bytes; each word is sent least-significant byte first.
  - Then CSUM: XOR of all payload bytes (length bytes excluded).
- States and transitions:
  - IDLE: `in_ready` = 0. An accepted `start` goes to LEN0 and clears `error`, `words_written`, byte index, and running XOR.
  - LEN0: accept LEN_LO, go to LEN1.
  - LEN1: accept LEN_HI. If N == 0 or N > DEPTH, set `error` and go to IDLE. Otherwise go to DATA.
  - DATA: accept bytes and shift them into the word register at lane = byte index[1:0].
    - The running XOR updates on every payload byte.
    - On the 4th byte of a word, schedule a write to addr = `words_written`×4.
    - After the last byte of word N, go to CSUM.
  - CSUM: accept one byte. If it equals the running XOR, pulse `done`; otherwise set `error`. Then go to IDLE.
- `in_ready` = 1 in LEN0, LEN1, DATA and CSUM. There is no backpressure, because the memory accepts one write per cycle.
- `cpu_hold` = 1 in every state except IDLE.
- `start` outside IDLE is ignored.
- Payload words already written stay in memory when an error occurs; the image is simply marked bad.
- After a length error, the loader consumes no further bytes; the source must drain the rest of the stream itself.

## Timing
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 0, `done` 0, `error` 0, `words_written` 0; state IDLE.
- `start` accepted at cycle t: `cpu_hold` = 1 and `in_ready` = 1 from cycle t+1.
- 4th byte of a word accepted at cycle k:
  - At cycle k+1, `mem_we` = 1 for exactly one cycle with `mem_addr` and `mem_wdata` valid.
  - `words_written` increments at cycle k+1.
  - `mem_addr` and `mem_wdata` hold their values until the next write.
- CSUM byte accepted at cycle k:
  - At k+1, `done` (1 cycle) or `error` (sticky) asserts, and `cpu_hold` = 0 and `in_ready` = 0.
  - The final data write happened at least one cycle earlier.
- Bad length (LEN_HI accepted at cycle k): `error` = 1 and `cpu_hold` = 0 at k+1; no write is issued.
- `in_valid` gaps stall the byte index; no state changes without a transfer.
- Maximum throughput: one byte per cycle, so one word write per 4 cycles.
- `rst` asserted in any state: all outputs go immediately to their reset values and any partial word is discarded. After reset release, a new `start` works normally.

## Test plan
- Two-word load:
  - Stimulus: `start`, then bytes 02 00 | 93 00 10 00 | 13 01 20 00 | B1, one per cycle.
  - Required: write 0x00100093 @0x0, then write 0x00200113 @0x4; `done` pulse one cycle after the B1 byte; `error` = 0; `words_written` = 2; `cpu_hold` 1→0.
- Checksum mismatch:
  - Stimulus: same stream with final byte 00.
  - Required: both writes occur, `error` = 1, no `done`, `error` stays 1 until the next `start`.
- Length 0:
  - Stimulus: bytes 00 00.
  - Required: `error` = 1 one cycle after LEN_HI, `mem_we` never asserts, `in_ready` = 0 afterwards.
- Length over DEPTH:
  - Stimulus: bytes 01 04 (N = 1025).
  - Required: `error` = 1, no writes.
- Gaps and ignored start:
  - Stimulus: the two-word stream with `in_valid` low for 3 cycles between every byte, plus a `start` pulse mid-DATA.
  - Required: identical writes and `done`; the mid-load `start` has no effect.
- Reset mid-load:
  - Stimulus: assert `rst` after 6 payload bytes.
  - Required: all outputs 0 immediately and only the first write has occurred. A fresh two-word load then passes with `words_written` = 2.
